gpu_task_dispatcher: RTL and testbench
======================================

# gpu_task_dispatcher

Task-scheduler end of the core instruction-load interface. Holds one 16-word kernel written by the host and broadcasts it to a selected set of GPU cores over the shared `instruction` bus using per-core `val_ins`, gated by per-core `rtr`. It then collects each core's `ready` completion flag and reports a done pulse, a completion mask, a timeout flag and the kernel run time. It sits between the host/command logic and the core array.

## Interface
- `NUM_CORES`, 8: number of attached cores; width of the per-core vectors.
- `PROG_DEPTH`, 16: kernel length in words. Fixed to the core's instruction store size; must be 16.
- `TIMEOUT`, 4096: maximum cycles spent in WAIT_RTR or WAIT_READY; range 1..65535.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `prog_we` in 1: host program-buffer write strobe.
- `prog_addr` in 4: program-buffer word address.
- `prog_data` in 16: program word.
- `start` in 1: single-cycle launch request.
- `core_mask` in NUM_CORES: target cores, sampled with `start`.
- `rtr` in NUM_CORES: per-core ready-to-receive.
- `ready` in NUM_CORES: per-core kernel-complete flag. Sticky in the core until its next `val_ins`.
- `val_ins` out NUM_CORES: per-core instruction-valid.
- `instruction` out 16: broadcast instruction word.
- `busy` out 1: high from the cycle after `start` is accepted until `done`.
- `done` out 1: one-cycle completion pulse.
- `done_mask` out NUM_CORES: cores that reported `ready`; valid from `done` until the next accepted `start`.
- `timeout` out 1: the last run ended on timeout; valid with `done_mask`.
- `run_cycles` out 16: cycles spent in WAIT_READY; saturates at 16'hFFFF.

## Operation
- All outputs are registered.
- The program buffer is 16x16 and has no reset. Its contents are retained across `reset`.
- A `prog_we` write takes effect only while `busy`=0. A write and a `start` in the same cycle are both accepted, and the new word is the one dispatched.
- FSM states: IDLE, WAIT_RTR, SEND, WAIT_READY, DONE.
- IDLE:
  - `start` with `core_mask`!=0: latch the mask, clear `done_mask`/`timeout`/`run_cycles`, go to WAIT_RTR.
  - `start` with `core_mask`==0: go to DONE, with `done_mask`=0 and `timeout`=0.
- WAIT_RTR: when `(rtr & mask)==mask`, go to SEND with word index 0. If the state counter reaches TIMEOUT first, go to DONE with `timeout`=1 and `done_mask`=0.
- SEND:
  - Each cycle drive `val_ins`=mask and `instruction`=prog[idx], then increment idx.
  - After index 15, go to WAIT_READY.
  - `rtr` is not rechecked in SEND, because a core in its receive state accepts every valid word.
  - Unmasked `val_ins` bits are always 0.
- WAIT_READY:
  - `done_mask |= ready & mask` every cycle. Sticky core `ready` values left over from earlier runs were cleared by the first word of this run, so no filtering is needed.
  - `run_cycles` increments every cycle, saturating.
  - Exit to DONE when `done_mask==mask`, or when the counter reaches TIMEOUT (then `timeout`=1).
- DONE: `done`=1 for one cycle, `busy`=0, return to IDLE.
- A `start` received while `busy`=1 is ignored.
- The state counter is cleared on every state entry.

## Timing
- Reset values: `val_ins`=0, `instruction`=0, `busy`=0, `done`=0, `done_mask`=0, `timeout`=0, `run_cycles`=0, state IDLE. Reset mid-run drops `val_ins` immediately and does not complete the run.
- With `rtr` already high: `start` is sampled at edge N, `busy`=1 after N, `val_ins` is first high after edge N+2, and it stays high for exactly 16 consecutive cycles carrying words 0..15 in order.
- `val_ins` is low the cycle after word 15.
- `ready` is first sampled in the first WAIT_READY cycle. `done` is asserted on the edge after the cycle in which the final mask bit was sampled.
- Zero-mask `start`: `done` is asserted after edge N+1.
- Timeout: `done` fires on the edge after the TIMEOUT-th cycle in the state.
- On a timeout in WAIT_READY, `done_mask` holds the partial set of cores that completed.

## Test plan
- prog[k]=16'h1000+k, `core_mask`=8'h01, `rtr`=FF, `start` -> `val_ins`=01 for 16 consecutive cycles with `instruction` 1000..100F. Then `ready[0]`=1 after 10 cycles -> `done` pulse, `done_mask`=01, `timeout`=0, `run_cycles`=10.
- `core_mask`=8'h05 with `rtr[2]`=0 for 20 cycles -> no `val_ins` until `rtr[2]` rises. Then `val_ins`=05 for 16 cycles and `val_ins[1]` stays 0 throughout.
- Same mask, `ready[0]` at WAIT_READY cycle 5, `ready[2]` at cycle 30 -> no `done` before cycle 30, then `done_mask`=05 and `run_cycles`=30.
- TIMEOUT=64, mask 03, only `ready[1]` rises -> `done` after 64 cycles with `timeout`=1 and `done_mask`=02. A second case with `rtr`=0 -> timeout with `done_mask`=00 and no `val_ins`.
- `prog_we` to addr 3 and a second `start` while `busy` -> both ignored; the next run dispatches the old word 3. Zero-mask `start` -> `done` after edge N+1, no `val_ins`.
- Assert `reset` in the 8th SEND cycle -> `val_ins`=0 and `busy`=0 immediately. After release, a new `start` re-sends all 16 words from word 0 with the buffer contents intact.

Source files
------------

// File: rtl/gpu_task_dispatcher.sv
// Kernel dispatcher: stores a 16-word program and broadcasts it to a set of cores,
// then collects per-core completion and reports mask, timeout and run time.
module gpu_task_dispatcher #(
    parameter  int unsigned NUM_CORES  = 8,
    parameter  int unsigned PROG_DEPTH = 16,
    parameter  int unsigned TIMEOUT    = 4096,
    localparam int unsigned WORD_W     = 16,
    localparam int unsigned ADDR_W     = 4,
    localparam int unsigned CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 prog_we,
    input  logic [ADDR_W-1:0]    prog_addr,
    input  logic [WORD_W-1:0]    prog_data,
    input  logic                 start,
    input  logic [NUM_CORES-1:0] core_mask,
    input  logic [NUM_CORES-1:0] rtr,
    input  logic [NUM_CORES-1:0] ready,
    output logic [NUM_CORES-1:0] val_ins,
    output logic [WORD_W-1:0]    instruction,
    output logic                 busy,
    output logic                 done,
    output logic [NUM_CORES-1:0] done_mask,
    output logic                 timeout,
    output logic [CNT_W-1:0]     run_cycles
);

    typedef enum logic [2:0] {IDLE, WAIT_RTR, SEND, WAIT_READY, DONE} state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [ADDR_W-1:0]    idx, idx_nxt;
    logic [NUM_CORES-1:0] mask, mask_nxt;
    logic [NUM_CORES-1:0] val_ins_nxt;
    logic [WORD_W-1:0]    instruction_nxt;
    logic                 busy_nxt, done_nxt, timeout_nxt;
    logic [NUM_CORES-1:0] done_mask_nxt, merged;
    logic [CNT_W-1:0]     run_cycles_nxt;
    logic                 expired;

    logic [WORD_W-1:0]    prog [PROG_DEPTH];

    // Program buffer survives reset; host writes are locked out during a run.
    always_ff @(posedge clk) begin
        if (prog_we && !busy) begin
            prog[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            mask        <= '0;
            val_ins     <= '0;
            instruction <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            done_mask   <= '0;
            timeout     <= 1'b0;
            run_cycles  <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            idx         <= idx_nxt;
            mask        <= mask_nxt;
            val_ins     <= val_ins_nxt;
            instruction <= instruction_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            done_mask   <= done_mask_nxt;
            timeout     <= timeout_nxt;
            run_cycles  <= run_cycles_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        idx_nxt         = idx;
        mask_nxt        = mask;
        val_ins_nxt     = '0;
        instruction_nxt = instruction;
        busy_nxt        = busy;
        done_nxt        = 1'b0;
        done_mask_nxt   = done_mask;
        timeout_nxt     = timeout;
        run_cycles_nxt  = run_cycles;
        merged          = done_mask | (ready & mask);
        expired         = (cnt == CNT_W'(TIMEOUT - 1));

        unique case (state)
            IDLE: begin
                if (start) begin
                    busy_nxt       = 1'b1;
                    done_mask_nxt  = '0;
                    timeout_nxt    = 1'b0;
                    run_cycles_nxt = '0;
                    if (core_mask != '0) begin
                        mask_nxt  = core_mask;
                        state_nxt = WAIT_RTR;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            WAIT_RTR: begin
                if ((rtr & mask) == mask) begin
                    idx_nxt   = '0;
                    state_nxt = SEND;
                end else if (expired) begin
                    done_mask_nxt = '0;
                    timeout_nxt   = 1'b1;
                    done_nxt      = 1'b1;
                    busy_nxt      = 1'b0;
                    state_nxt     = DONE;
                end
            end
            SEND: begin
                val_ins_nxt     = mask;
                instruction_nxt = prog[idx];
                idx_nxt         = idx + ADDR_W'(1);
                if (idx == ADDR_W'(PROG_DEPTH - 1)) begin
                    state_nxt = WAIT_READY;
                end
            end
            WAIT_READY: begin
                done_mask_nxt  = merged;
                run_cycles_nxt = (run_cycles == '1) ? run_cycles : run_cycles + CNT_W'(1);
                if (merged == mask) begin
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = DONE;
                end else if (expired) begin
                    timeout_nxt = 1'b1;
                    done_nxt    = 1'b1;
                    busy_nxt    = 1'b0;
                    state_nxt   = DONE;
                end
            end
            DONE: begin
                // Run exits pulse done on entry; a zero-mask launch pulses it here.
                if (done) begin
                    state_nxt = IDLE;
                end else begin
                    done_nxt = 1'b1;
                    busy_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // State counter only runs while waiting and restarts on every state entry.
        if ((state == WAIT_RTR || state == WAIT_READY) && state_nxt == state) begin
            cnt_nxt = cnt + CNT_W'(1);
        end else begin
            cnt_nxt = '0;
        end
    end

endmodule

// File: tb/tb_gpu_task_dispatcher.sv
// Randomized bench for gpu_task_dispatcher; expectations come from a
// transaction-level timing model of each run.
module tb_gpu_task_dispatcher;

    localparam int NC = 8;
    localparam int TO = 64;

    logic          clk;
    logic          reset;
    logic          prog_we;
    logic [3:0]    prog_addr;
    logic [15:0]   prog_data;
    logic          start;
    logic [NC-1:0] core_mask;
    logic [NC-1:0] rtr;
    logic [NC-1:0] ready;
    logic [NC-1:0] val_ins;
    logic [15:0]   instruction;
    logic          busy;
    logic          done;
    logic [NC-1:0] done_mask;
    logic          timeout;
    logic [15:0]   run_cycles;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] prog_model [16];
    int          rr [NC];
    int          rd [NC];

    gpu_task_dispatcher #(.NUM_CORES(NC), .PROG_DEPTH(16), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .start(start), .core_mask(core_mask), .rtr(rtr),
        .ready(ready), .val_ins(val_ins), .instruction(instruction), .busy(busy),
        .done(done), .done_mask(done_mask), .timeout(timeout), .run_cycles(run_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic write_word(input logic [3:0] a, input logic [15:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        @(posedge clk); #1;
        prog_we = 1'b0;
        prog_model[a] = d;
    endtask

    // One launch. rr[c]: first WAIT_RTR cycle (1-based) with rtr[c] high.
    // rd[c]: first WAIT_READY cycle (1-based) with ready[c] high.
    task automatic run_case(input logic [NC-1:0] m, input bit noise, input bit wws);
        int e, t, d, rc;
        bit rtr_to, to;
        logic [NC-1:0] dm, left, exp_v;
        logic [3:0]  wa;
        logic [15:0] wd;
        e = 1;
        for (int c = 0; c < NC; c++) if (m[c] && rr[c] > e) e = rr[c];
        rtr_to = (m != '0) && (e > TO);
        t = 0; dm = '0; to = 0; rc = 0;
        if (m == '0) begin
            d = 1;
        end else if (rtr_to) begin
            d = TO; to = 1;
        end else begin
            for (int c = 0; c < NC; c++) if (m[c] && rd[c] > t) t = rd[c];
            if (t <= TO) begin
                d = e + 16 + t; dm = m; rc = t;
            end else begin
                d = e + 16 + TO; to = 1; rc = TO;
                for (int c = 0; c < NC; c++) if (m[c] && rd[c] <= TO) dm[c] = 1'b1;
            end
        end
        left = NC'($urandom);
        wa = 4'($urandom); wd = 16'($urandom);
        start = 1'b1; core_mask = m;
        if (wws) begin
            prog_we = 1'b1; prog_addr = wa; prog_data = wd;
        end
        @(posedge clk); #1;
        start = 1'b0; prog_we = 1'b0; core_mask = NC'($urandom);
        if (wws) prog_model[wa] = wd;
        for (int p = 0; p <= d + 1; p++) begin
            check("busy", 32'(busy), 32'(p < d));
            check("done", 32'(done), 32'(p == d));
            exp_v = (!rtr_to && m != '0 && p >= e + 1 && p <= e + 16) ? m : '0;
            check("val_ins", 32'(val_ins), 32'(exp_v));
            if (exp_v != '0) check("instruction", 32'(instruction), 32'(prog_model[p-e-1]));
            if (p >= d) begin
                check("done_mask", 32'(done_mask), 32'(dm));
                check("timeout", 32'(timeout), 32'(to));
                if (m != '0) check("run_cycles", 32'(run_cycles), 32'(rc));
            end
            for (int c = 0; c < NC; c++) begin
                rtr[c] = (p + 1 >= rr[c]);
                if (m[c]) ready[c] = (rtr_to || p <= e + 1) ? left[c] : (p - e - 15 >= rd[c]);
                else ready[c] = 1'($urandom_range(0, 1));
            end
            if (noise && p <= d - 2) begin
                start     = ($urandom_range(0, 3) == 0);
                core_mask = NC'($urandom);
                prog_we   = ($urandom_range(0, 2) == 0) || (p == 1);
                prog_addr = (p == 1) ? 4'd3 : 4'($urandom);
                prog_data = 16'($urandom);
            end else begin
                start = 1'b0; prog_we = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0; prog_we = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_val_ins"}, 32'(val_ins), 32'(0));
        check({tag, "_instruction"}, 32'(instruction), 32'(0));
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_done"}, 32'(done), 32'(0));
        check({tag, "_done_mask"}, 32'(done_mask), 32'(0));
        check({tag, "_timeout"}, 32'(timeout), 32'(0));
        check({tag, "_run_cycles"}, 32'(run_cycles), 32'(0));
    endtask

    // Launch to all cores and pull reset during the 8th SEND cycle.
    task automatic reset_mid_send();
        start = 1'b1; core_mask = '1; rtr = '1; ready = '0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int p = 0; p < 8; p++) begin
            if (p >= 2) check("mid_val_ins", 32'(val_ins), 32'(8'hFF));
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #1;
        check_reset_values("mid_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            check("post_reset_done", 32'(done), 32'(0));
            check("post_reset_val_ins", 32'(val_ins), 32'(0));
        end
    endtask

    initial begin
        reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        start = 1'b0; core_mask = '0; rtr = '0; ready = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        reset = 1'b0;
        @(posedge clk); #1;
        check_reset_values("idle");

        for (int k = 0; k < 16; k++) write_word(4'(k), 16'h1000 + 16'(k));

        // Single core, ready after 10 cycles.
        for (int c = 0; c < NC; c++) begin rr[c] = 1; rd[c] = 1000; end
        rd[0] = 10;
        run_case(8'h01, 0, 0);

        // rtr[2] held low for 20 cycles; staggered completion.
        for (int c = 0; c < NC; c++) begin rr[c] = 1; rd[c] = 1000; end
        rr[2] = 21; rd[0] = 5; rd[2] = 30;
        run_case(8'h05, 0, 0);

        // Partial completion timeout, then rtr never asserted.
        for (int c = 0; c < NC; c++) begin rr[c] = 1; rd[c] = 1000; end
        rd[1] = 3;
        run_case(8'h03, 0, 0);
        for (int c = 0; c < NC; c++) begin rr[c] = 1000; rd[c] = 1; end
        run_case(8'h03, 0, 0);

        // Writes and starts while busy are ignored; next run sends old word 3.
        for (int c = 0; c < NC; c++) begin rr[c] = 1; rd[c] = 4 + c; end
        run_case(8'h0F, 1, 0);
        run_case(8'h0F, 0, 0);
        run_case(8'h00, 0, 0);
        run_case(8'h30, 0, 1);

        reset_mid_send();
        for (int c = 0; c < NC; c++) begin rr[c] = 1; rd[c] = $urandom_range(1, 20); end
        run_case(8'hFF, 0, 0);

        for (int r = 0; r < 40; r++) begin
            logic [NC-1:0] m;
            m = NC'($urandom);
            if ($urandom_range(0, 9) == 0) m = '0;
            for (int c = 0; c < NC; c++) begin
                rr[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 75) : 1;
                rd[c] = ($urandom_range(0, 7) == 0) ? 1000 : $urandom_range(1, 40);
            end
            for (int w = 0; w < $urandom_range(0, 2); w++) write_word(4'($urandom), 16'($urandom));
            run_case(m, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
